reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Producer-side register hazard tracker for the in-order core pipeline. Decode reports each issued instruction's destination register. Writeback and execute-stage kills retire those destinations. The block keeps a per-register in-flight write count and drives the decode stall. It replaces per-stage address comparison with recorded write state, so pipeline depth no longer sets the comparator count.

## Interface
Parameters:
- NUM_REGS, 32, architectural integer registers; x0 is never tracked.
- MAX_INFLIGHT, 3, maximum outstanding writes to one register; counter width is $clog2(MAX_INFLIGHT+1).

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset.
- issue_valid_D  input  1  decode holds a valid instruction attempting issue.
- rd_addr_D  input  5  destination register of the decode instruction.
- rd_we_D  input  1  the decode instruction writes rd.
- rs1_addr_D  input  5  source 1 address.
- rs2_addr_D  input  5  source 2 address.
- wb_valid_W  input  1  writeback commits a register write this cycle.
- wb_addr_W  input  5  writeback destination.
- kill_valid_E  input  1  a killed instruction leaves execute; its write is cancelled.
- kill_addr_E  input  5  destination of the killed instruction.
- stall_D  output  1  hold decode; no issue this cycle.
- pending  output  NUM_REGS  bit i set when count[i] != 0; bit 0 is always 0.
- busy  output  1  OR of pending.
- err  output  1  sticky: a retire was attempted on a zero count.

## Operation
- Each register i in 1..NUM_REGS-1 has a count[i] with range 0..MAX_INFLIGHT.
- Define issue_fire = issue_valid_D & ~stall_D & rd_we_D & (rd_addr_D != 0).
- Inc[i] = issue_fire & (rd_addr_D == i).
- Dec[i] = number of retire events addressed to i: wb_valid_W and kill_valid_E, each with its address != 0. Dec[i] can be 0, 1 or 2.
- Next count[i] = count[i] + Inc[i] - Dec[i]. Inc and Dec on the same register in the same cycle cancel.
- If Dec[i] exceeds count[i] + Inc[i]:
  - count[i] clamps to 0.
  - err sets and stays set until reset.
- hazard(a) = (a != 0) & (count[a] != 0), subject to the bypass rule in Configuration.
- stall_D = issue_valid_D & (hazard(rs1) | hazard(rs2) | (rd_we_D & rd_addr_D != 0 & count[rd_addr_D] == MAX_INFLIGHT)).
- stall_D is purely combinational from the inputs and the registered counts. It never depends on its own value.
- Writes to x0, and retires of x0, are ignored everywhere.
- Sources do not need to be registered while stalling.

## Timing
- Reset (asynchronous assert, synchronous release):
  - all counts = 0
  - pending = 0, busy = 0, err = 0
  - stall_D follows the combinational equation; with counts at 0 it is low except at MAX_INFLIGHT = 0.
- An issue in cycle N makes pending[rd] visible in cycle N+1. A dependent instruction in decode during N+1 stalls.
- A writeback in cycle N clears pending in cycle N+1 when its count was 1.
- reset_n asserted mid-operation discards all in-flight state immediately. The pipeline is reset alongside.

## Configuration
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined:
  - hazard(a) treats count[a] as count[a] - 1 when wb_valid_W & wb_addr_W == a.
  - A source whose last outstanding write commits this cycle does not stall. This requires a write-through register file.
- Undefined: hazard uses the registered count only. The consumer stalls one extra cycle after the commit.

## Structure
- Shared package core_pkg holds:
  - typedef reg_addr_t (logic [4:0])
  - NUM_REGS
  - MAX_INFLIGHT default
- Sub-module sb_counter: one saturating up/down counter per register, with inc, dec1, dec2, and a zero flag plus an underflow flag. It is instantiated in a generate loop for i = 1..NUM_REGS-1.

## Test plan
- Issue rd=x5, then in the next cycle issue rs1=x5 → stall_D=1 in that cycle. wb x5 two cycles later → stall_D=0 one cycle after (the same cycle under SCOREBOARD_WB_BYPASS_EN).
- Issue rd=x0, then rs2=x0 → stall_D stays 0; pending=0.
- Three back-to-back issues to x7 (count=3), then a fourth issue to x7 → stall_D=1 while the sources are clear. One wb x7 → the issue proceeds in the next cycle.
- Same cycle: issue rd=x9 with count[x9]=1 and wb x9 → count stays 1, pending[9]=1.
- Same cycle: wb x4 and kill x4 with count[x4]=2 → count=0, err=0. A further wb x4 → err=1 and stays set.
- Count x3=2 and busy=1, then pulse reset_n low mid-cycle → pending=0, busy=0, err=0 asynchronously.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared core definitions for the register scoreboard: register address
// type, default architectural sizes and the counter-width helper.
package core_pkg;

   typedef logic [4:0] reg_addr_t;

   localparam int NUM_REGS     = 32;
   localparam int MAX_INFLIGHT = 3;

   // Width of a per-register in-flight counter; never narrower than one bit
   // so a degenerate MAX_INFLIGHT of 0 still elaborates.
   function automatic int cnt_width(input int max_inflight);
      return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
   endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode / writeback / kill bundle between the pipeline and the register
// scoreboard. master = pipeline side, slave = scoreboard side.
interface reg_scoreboard_if #(
   parameter int NUM_REGS = core_pkg::NUM_REGS
);
   import core_pkg::*;

   logic                issue_valid_D;
   reg_addr_t           rd_addr_D;
   logic                rd_we_D;
   reg_addr_t           rs1_addr_D;
   reg_addr_t           rs2_addr_D;
   logic                wb_valid_W;
   reg_addr_t           wb_addr_W;
   logic                kill_valid_E;
   reg_addr_t           kill_addr_E;
   logic                stall_D;
   logic [NUM_REGS-1:0] pending;
   logic                busy;
   logic                err;

   modport master (
      output issue_valid_D, rd_addr_D, rd_we_D, rs1_addr_D, rs2_addr_D,
      output wb_valid_W, wb_addr_W, kill_valid_E, kill_addr_E,
      input  stall_D, pending, busy, err
   );

   modport slave (
      input  issue_valid_D, rd_addr_D, rd_we_D, rs1_addr_D, rs2_addr_D,
      input  wb_valid_W, wb_addr_W, kill_valid_E, kill_addr_E,
      output stall_D, pending, busy, err
   );

endinterface

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: in-flight write counter for one architectural register.
// One increment (issue) and up to two decrements (writeback, kill) per
// cycle; clamps to 0 on underflow and flags it, saturates at MAX_INFLIGHT.
module sb_counter #(
   parameter int MAX_INFLIGHT = 3,
   parameter int CW           = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          inc_i,
   input  logic          dec1_i,
   input  logic          dec2_i,
   output logic [CW-1:0] count_o,
   output logic          zero_o,
   output logic          underflow_o
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   int            net_s;

   // Net change this cycle; an inc and a dec on the same cycle cancel.
   always_comb begin
      net_s       = int'(count_q) + int'(inc_i) - int'(dec1_i) - int'(dec2_i);
      count_d     = count_q;
      underflow_o = 1'b0;
      if (net_s < 0) begin
         count_d     = '0;
         underflow_o = 1'b1;
      end else if (net_s > MAX_INFLIGHT) begin
         count_d = CW'(MAX_INFLIGHT);
      end else begin
         count_d = CW'(net_s);
      end
   end

   // Count register; reset discards all outstanding writes at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) count_q <= '0;
      else          count_q <= count_d;
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: producer-side register hazard tracker. Keeps an in-flight
// write count per register (x0 untracked) and drives the decode stall.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a source whose last outstanding
// write commits this cycle is not a hazard (write-through register file).
module reg_scoreboard #(
   parameter int NUM_REGS     = core_pkg::NUM_REGS,
   parameter int MAX_INFLIGHT = core_pkg::MAX_INFLIGHT
) (
   input  logic             clk,
   input  logic             reset_n,
   reg_scoreboard_if.slave  sb
);
   import core_pkg::*;

   localparam int CW = cnt_width(MAX_INFLIGHT);

   logic [CW-1:0]       count [NUM_REGS];
   logic [NUM_REGS-1:0] nonzero;
   logic [NUM_REGS-1:0] underflow;
   logic                issue_fire;
   logic                hz_rs1;
   logic                hz_rs2;
   logic                rd_full;
   logic                err_q;
   logic                err_d;

   // x0 never holds a count.
   assign count[0]     = '0;
   assign nonzero[0]   = 1'b0;
   assign underflow[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
         logic zero_w;
         sb_counter #(
            .MAX_INFLIGHT (MAX_INFLIGHT),
            .CW           (CW)
         ) u_cnt (
            .clk         (clk),
            .reset_n     (reset_n),
            .inc_i       (issue_fire && (sb.rd_addr_D == reg_addr_t'(gi))),
            .dec1_i      (sb.wb_valid_W && (sb.wb_addr_W == reg_addr_t'(gi))),
            .dec2_i      (sb.kill_valid_E && (sb.kill_addr_E == reg_addr_t'(gi))),
            .count_o     (count[gi]),
            .zero_o      (zero_w),
            .underflow_o (underflow[gi])
         );
         assign nonzero[gi] = ~zero_w;
      end
   endgenerate

   // Source hazards and destination-full check from the registered counts.
   always_comb begin
      hz_rs1  = (sb.rs1_addr_D != '0) && (count[sb.rs1_addr_D] != '0);
      hz_rs2  = (sb.rs2_addr_D != '0) && (count[sb.rs2_addr_D] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
      if (sb.wb_valid_W && (sb.wb_addr_W == sb.rs1_addr_D) &&
          (count[sb.rs1_addr_D] == CW'(1)))
         hz_rs1 = 1'b0;
      if (sb.wb_valid_W && (sb.wb_addr_W == sb.rs2_addr_D) &&
          (count[sb.rs2_addr_D] == CW'(1)))
         hz_rs2 = 1'b0;
`endif
      rd_full = sb.rd_we_D && (sb.rd_addr_D != '0) &&
                (count[sb.rd_addr_D] == CW'(MAX_INFLIGHT));
   end

   assign sb.stall_D = sb.issue_valid_D & (hz_rs1 | hz_rs2 | rd_full);
   assign issue_fire = sb.issue_valid_D & ~sb.stall_D & sb.rd_we_D &
                       (sb.rd_addr_D != '0);

   assign err_d = err_q | (|underflow);

   // Sticky error: any retire against an empty count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign sb.pending = nonzero;
   assign sb.busy    = |nonzero;
   assign sb.err     = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a per-register count model.
module tb_reg_scoreboard;
   import core_pkg::*;

   localparam int NR = 32;
   localparam int MI = 3;
`ifdef SCOREBOARD_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   reg_scoreboard_if #(.NUM_REGS(NR)) sb_if ();

   reg_scoreboard #(.NUM_REGS(NR), .MAX_INFLIGHT(MI)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sb      (sb_if)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cnt [NR];
   bit m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model hazard: a source is blocked while any write to it is outstanding.
   function automatic bit m_hazard(input int a);
      int eff;
      eff = cnt[a];
      if (BYP && sb_if.wb_valid_W && int'(sb_if.wb_addr_W) == a) eff = eff - 1;
      return (a != 0) && (eff > 0);
   endfunction

   function automatic bit m_stall();
      int rd;
      rd = int'(sb_if.rd_addr_D);
      return sb_if.issue_valid_D &&
             (m_hazard(int'(sb_if.rs1_addr_D)) || m_hazard(int'(sb_if.rs2_addr_D)) ||
              (sb_if.rd_we_D && rd != 0 && cnt[rd] == MI));
   endfunction

   // Compare every cycle mid-period, then advance the model for the next edge.
   always @(negedge clk) begin
      logic [NR-1:0] exp_pend;
      bit s;
      int v;
      if (!reset_n) begin
         for (int i = 0; i < NR; i++) cnt[i] = 0;
         m_err = 1'b0;
      end
      exp_pend = '0;
      for (int i = 1; i < NR; i++) if (cnt[i] != 0) exp_pend[i] = 1'b1;
      s = m_stall();
      chk("stall_D", sb_if.stall_D, s);
      chk("pending", sb_if.pending, exp_pend);
      chk("busy",    sb_if.busy, |exp_pend);
      chk("err",     sb_if.err, m_err);
      if (reset_n) begin
         for (int i = 1; i < NR; i++) begin
            v = cnt[i];
            if (sb_if.issue_valid_D && !s && sb_if.rd_we_D && int'(sb_if.rd_addr_D) == i) v++;
            if (sb_if.wb_valid_W && int'(sb_if.wb_addr_W) == i) v--;
            if (sb_if.kill_valid_E && int'(sb_if.kill_addr_E) == i) v--;
            if (v < 0) begin
               v = 0;
               m_err = 1'b1;
            end
            cnt[i] = v;
         end
      end
   end

   // Drive one cycle's inputs shortly after the edge; returns at edge+3.
   task automatic drive(input bit iv, input int rd, input bit we, input int r1, input int r2,
                        input bit wv, input int wa, input bit kv, input int ka);
      @(posedge clk);
      #2;
      sb_if.issue_valid_D = iv;
      sb_if.rd_addr_D     = reg_addr_t'(rd);
      sb_if.rd_we_D       = we;
      sb_if.rs1_addr_D    = reg_addr_t'(r1);
      sb_if.rs2_addr_D    = reg_addr_t'(r2);
      sb_if.wb_valid_W    = wv;
      sb_if.wb_addr_W     = reg_addr_t'(wa);
      sb_if.kill_valid_E  = kv;
      sb_if.kill_addr_E   = reg_addr_t'(ka);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Retire target: mostly a register with writes outstanding, sometimes random.
   function automatic int pick_retire();
      int cands [$];
      for (int i = 1; i < 8; i++) if (cnt[i] != 0) cands.push_back(i);
      if (cands.size() == 0 || $urandom_range(0, 9) == 0) return int'($urandom_range(0, 31));
      return cands[$urandom_range(0, cands.size() - 1)];
   endfunction

   initial begin
      sb_if.issue_valid_D = 0; sb_if.rd_addr_D = '0; sb_if.rd_we_D = 0;
      sb_if.rs1_addr_D = '0; sb_if.rs2_addr_D = '0;
      sb_if.wb_valid_W = 0; sb_if.wb_addr_W = '0;
      sb_if.kill_valid_E = 0; sb_if.kill_addr_E = '0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;

      idle();
      chk("rst_pending", sb_if.pending, 0);
      chk("rst_busy",    sb_if.busy, 0);
      chk("rst_err",     sb_if.err, 0);

      // RAW on x5, resolved by writeback
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0); chk("t1_issue_x5", sb_if.stall_D, 0);
      drive(1, 0, 0, 5, 0, 0, 0, 0, 0); chk("t1_raw_stall", sb_if.stall_D, 1);
      chk("t1_pend5", sb_if.pending[5], 1);
      drive(1, 0, 0, 5, 0, 1, 5, 0, 0); chk("t1_wb_cycle", sb_if.stall_D, BYP ? 0 : 1);
      drive(1, 0, 0, 5, 0, 0, 0, 0, 0); chk("t1_after_wb", sb_if.stall_D, 0);
      chk("t1_pend5_clr", sb_if.pending[5], 0);

      // x0 is never tracked
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0); chk("t2_issue_x0", sb_if.stall_D, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); chk("t2_rs2_x0", sb_if.stall_D, 0);
      chk("t2_pending", sb_if.pending, 0);

      // Saturation at MAX_INFLIGHT on x7
      for (int k = 0; k < 3; k++) begin
         drive(1, 7, 1, 0, 0, 0, 0, 0, 0); chk("t3_fill", sb_if.stall_D, 0);
      end
      drive(1, 7, 1, 0, 0, 0, 0, 0, 0); chk("t3_full_stall", sb_if.stall_D, 1);
      chk("t3_model_cnt7", cnt[7], 3);
      chk("t3_pend7", sb_if.pending[7], 1);
      drive(1, 7, 1, 0, 0, 1, 7, 0, 0); chk("t3_wb_cycle", sb_if.stall_D, 1);
      drive(1, 7, 1, 0, 0, 0, 0, 0, 0); chk("t3_proceeds", sb_if.stall_D, 0);
      for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 1, 7, 0, 0);
      idle(); chk("t3_drained", sb_if.pending[7], 0);

      // Same-cycle issue and writeback on x9 cancel
      drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
      drive(1, 9, 1, 0, 0, 1, 9, 0, 0); chk("t4_issue_wb", sb_if.stall_D, 0);
      idle(); chk("t4_pend9", sb_if.pending[9], 1);
      chk("t4_model_cnt9", cnt[9], 1);
      drive(0, 0, 0, 0, 0, 1, 9, 0, 0);
      idle(); chk("t4_pend9_clr", sb_if.pending[9], 0);

      // Double retire on x4, then an underflow
      drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
      drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 4, 1, 4); chk("t5_pend4", sb_if.pending[4], 1);
      idle(); chk("t5_pend4_clr", sb_if.pending[4], 0);
      chk("t5_no_err", sb_if.err, 0);
      drive(0, 0, 0, 0, 0, 1, 4, 0, 0);
      idle(); chk("t5_err_set", sb_if.err, 1);
      idle(); idle(); chk("t5_err_sticky", sb_if.err, 1);

      // Asynchronous reset mid-cycle
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
      idle(); chk("t6_pend3", sb_if.pending[3], 1);
      chk("t6_busy", sb_if.busy, 1);
      reset_n = 1'b0;
      #1;
      chk("t6_async_pending", sb_if.pending, 0);
      chk("t6_async_busy", sb_if.busy, 0);
      chk("t6_async_err", sb_if.err, 0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;

      // Randomized traffic on a small register window to provoke hazards
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               $urandom_range(0, 1) == 1, pick_retire(),
               $urandom_range(0, 6) == 0, pick_retire());
         if (c % 700 == 699) begin
            reset_n = 1'b0;
            @(posedge clk);
            #2 reset_n = 1'b1;
         end
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
